// File: rtl/goomba_spawner.sv
// goomba_spawner
//   Initiator side of the goomba start/kill interface. Holds the level spawn
//   table, tracks the scroll column from Shift pulses, and when the next table
//   entry comes within LOOKAHEAD columns, issues a one-cycle start (with
//   spawnX/spawnY) to the lowest free goomba slot. level_restart broadcasts a
//   one-cycle kill to every slot and rewinds the level.
//
// Optional build macro:
//   GOOMBA_SPAWN_DROP_EN  entries that have already scrolled more than
//                         LOOKAHEAD+2 columns past are skipped while waiting
//                         for a free slot, instead of waiting indefinitely.
//
// Ports:
//   Clk, Reset_n           clock, asynchronous active-low reset
//   run                    spawning enabled while high
//   Shift                  one pulse per one-column screen shift
//   level_restart          one-cycle restart pulse
//   goomba_alive[N_SLOTS]  isAlive of each goomba slot
//   tbl_we/tbl_addr/tbl_col/tbl_y   spawn table write port
//   start[N_SLOTS]         registered one-hot start pulse
//   kill[N_SLOTS]          registered kill pulse (all slots)
//   spawnX, spawnY         spawn position, non-zero only while start is high
//   busy                   FSM not idle
//   done                   table exhausted (registered)
//   active_count           number of live goombas

module goomba_spawner #(
  parameter int         N_SLOTS   = 4,
  parameter int         TBL_DEPTH = 16,
  parameter logic [7:0] LOOKAHEAD = 8'd12,
  parameter logic [9:0] SPAWN_X   = 10'd500
) (
  input  logic                          Clk,
  input  logic                          Reset_n,
  input  logic                          run,
  input  logic                          Shift,
  input  logic                          level_restart,
  input  logic [N_SLOTS-1:0]            goomba_alive,
  input  logic                          tbl_we,
  input  logic [$clog2(TBL_DEPTH)-1:0]  tbl_addr,
  input  logic [7:0]                    tbl_col,
  input  logic [9:0]                    tbl_y,
  output logic [N_SLOTS-1:0]            start,
  output logic [N_SLOTS-1:0]            kill,
  output logic [9:0]                    spawnX,
  output logic [9:0]                    spawnY,
  output logic                          busy,
  output logic                          done,
  output logic [3:0]                    active_count
);

  localparam int AW = $clog2(TBL_DEPTH);
  localparam int IW = AW + 1;                       // next_idx must reach TBL_DEPTH
  localparam int TW = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;

  typedef enum logic [1:0] {IDLE, SEEK, ISSUE, HOLD} state_t;

  state_t state, state_n;

  logic                 tbl_valid [TBL_DEPTH];
  logic [7:0]           tbl_col_mem [TBL_DEPTH];
  logic [9:0]           tbl_y_mem [TBL_DEPTH];

  logic [7:0]           level_col;
  logic [IW-1:0]        next_idx;
  logic [N_SLOTS-1:0]   pending;
  logic [TW-1:0]        target_q, target_n, target;
  logic                 have_free;
  logic [N_SLOTS-1:0]   free;

  logic                 idx_ok, cur_valid, due, stale;
  logic [AW-1:0]        idx;
  logic [7:0]           cur_col;
  logic [9:0]           cur_y;
  logic [8:0]           reach;

  logic [N_SLOTS-1:0]   start_n, kill_n;
  logic [9:0]           spawn_x_n, spawn_y_n;
  logic                 idx_inc, set_pending;

  // Table: valid bits reset, payload does not need to.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int unsigned i = 0; i < TBL_DEPTH; i++) tbl_valid[i] <= 1'b0;
    end else if (tbl_we) begin
      tbl_valid[tbl_addr] <= 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (tbl_we) begin
      tbl_col_mem[tbl_addr] <= tbl_col;
      tbl_y_mem[tbl_addr]   <= tbl_y;
    end
  end

  // Current entry lookup and spawn condition (9-bit compare avoids overflow).
  always_comb begin
    idx_ok    = (next_idx < IW'(TBL_DEPTH));
    idx       = next_idx[AW-1:0];
    cur_valid = idx_ok && tbl_valid[idx];
    cur_col   = tbl_col_mem[idx];
    cur_y     = tbl_y_mem[idx];
    reach     = {1'b0, level_col} + {1'b0, LOOKAHEAD};
    due       = run && cur_valid && ({1'b0, cur_col} <= reach);
`ifdef GOOMBA_SPAWN_DROP_EN
    stale     = {1'b0, level_col} > ({1'b0, cur_col} + {1'b0, LOOKAHEAD} + 9'd2);
`else
    stale     = 1'b0;
`endif
  end

  // Lowest free slot: iterate downwards so the lowest index is assigned last.
  always_comb begin
    free      = ~goomba_alive & ~pending;
    target    = '0;
    have_free = 1'b0;
    for (int unsigned i = N_SLOTS; i > 0; i--) begin
      if (free[i-1]) begin
        target    = TW'(i - 1);
        have_free = 1'b1;
      end
    end
  end

  always_comb begin
    active_count = '0;
    for (int unsigned i = 0; i < N_SLOTS; i++) begin
      active_count = active_count + 4'(goomba_alive[i]);
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_n;
  end

  // Next state and next values of the registered outputs. start/spawn values
  // are loaded on the SEEK->ISSUE transition so they are high during ISSUE.
  always_comb begin
    state_n     = state;
    target_n    = target_q;
    start_n     = '0;
    kill_n      = '0;
    spawn_x_n   = '0;
    spawn_y_n   = '0;
    idx_inc     = 1'b0;
    set_pending = 1'b0;
    case (state)
      IDLE: if (due) state_n = SEEK;
      SEEK: begin
        if (!run) begin
          state_n = IDLE;
        end else if (stale) begin
          idx_inc = 1'b1;
          state_n = IDLE;
        end else if (have_free) begin
          state_n   = ISSUE;
          target_n  = target;
          start_n   = N_SLOTS'(1) << target;
          spawn_x_n = SPAWN_X;
          spawn_y_n = cur_y;
        end
      end
      ISSUE: begin
        set_pending = 1'b1;
        idx_inc     = 1'b1;
        state_n     = HOLD;
      end
      HOLD:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    // Restart overrides everything in flight; a start never accompanies kill.
    if (level_restart) begin
      state_n     = IDLE;
      start_n     = '0;
      spawn_x_n   = '0;
      spawn_y_n   = '0;
      kill_n      = '1;
      idx_inc     = 1'b0;
      set_pending = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      start     <= '0;
      kill      <= '0;
      spawnX    <= '0;
      spawnY    <= '0;
      target_q  <= '0;
      level_col <= '0;
      next_idx  <= '0;
      pending   <= '0;
      done      <= 1'b0;
    end else begin
      start    <= start_n;
      kill     <= kill_n;
      spawnX   <= spawn_x_n;
      spawnY   <= spawn_y_n;
      target_q <= target_n;
      done     <= !cur_valid;
      if (level_restart) begin
        level_col <= '0;
        next_idx  <= '0;
        pending   <= '0;
      end else begin
        if (Shift && run && (level_col != 8'hFF)) level_col <= level_col + 8'd1;
        if (idx_inc) next_idx <= next_idx + IW'(1);
        // Pending bridges the gap until the goomba reports alive.
        pending <= (pending & ~goomba_alive)
                 | (set_pending ? (N_SLOTS'(1) << target_q) : '0);
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_goomba_spawner.sv
module tb_goomba_spawner;

  logic       Clk = 1'b0;
  logic       Reset_n, run, Shift, level_restart, tbl_we;
  logic [3:0] goomba_alive, tbl_addr;
  logic [7:0] tbl_col;
  logic [9:0] tbl_y;
  logic [3:0] start, kill, active_count;
  logic [9:0] spawnX, spawnY;
  logic       busy, done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] s;
    logic [9:0] x;
    logic [9:0] y;
  } exp_t;
  exp_t exp_q[$];

  goomba_spawner #(
    .N_SLOTS(4), .TBL_DEPTH(16), .LOOKAHEAD(8'd12), .SPAWN_X(10'd500)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .run(run), .Shift(Shift),
    .level_restart(level_restart), .goomba_alive(goomba_alive),
    .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_col(tbl_col), .tbl_y(tbl_y),
    .start(start), .kill(kill), .spawnX(spawnX), .spawnY(spawnY),
    .busy(busy), .done(done), .active_count(active_count)
  );

  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic write_entry(input logic [3:0] a, input logic [7:0] c, input logic [9:0] y);
    tbl_we = 1'b1; tbl_addr = a; tbl_col = c; tbl_y = y;
    tick();
    tbl_we = 1'b0;
  endtask

  task automatic restart_pulse(input string tag);
    level_restart = 1'b1;
    tick();
    level_restart = 1'b0;
    check({tag, "_kill"}, kill, 4'hF);
    check({tag, "_kill_nostart"}, start, 4'h0);
    check({tag, "_kill_idle"}, busy, 1'b0);
    tick();
    check({tag, "_kill_end"}, kill, 4'h0);
  endtask

  // Waits (bounded) for a start pulse, then checks it against the scoreboard.
  task automatic wait_start(input string tag, input int max, output int cyc);
    exp_t e;
    bit   found;
    found = 1'b0;
    cyc   = 0;
    while (!found && cyc < max) begin
      tick();
      cyc++;
      if (start != 4'h0) found = 1'b1;
    end
    check({tag, "_seen"}, found, 1'b1);
    if (found) begin
      check({tag, "_sb"}, exp_q.size() > 0, 1'b1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check({tag, "_start"}, start, e.s);
        check({tag, "_x"}, spawnX, e.x);
        check({tag, "_y"}, spawnY, e.y);
      end
    end
  endtask

  initial begin
    int   c, c2;
    logic [3:0] any;

    Reset_n = 1'b0; run = 1'b0; Shift = 1'b0; level_restart = 1'b0;
    goomba_alive = '0; tbl_we = 1'b0; tbl_addr = '0; tbl_col = '0; tbl_y = '0;
    #2;
    check("rst_start", start, 0);
    check("rst_kill", kill, 0);
    check("rst_x", spawnX, 0);
    check("rst_y", spawnY, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    tick(); tick();
    Reset_n = 1'b1;
    tick();
    check("empty_done", done, 1);

    // Immediate spawn of an entry already in range.
    write_entry(4'd0, 8'd5, 10'd400);
    exp_q.push_back('{4'b0001, 10'd500, 10'd400});
    run = 1'b1;
    wait_start("t1", 4, c);
    check("t1_latency", c <= 3, 1);
    tick();
    check("t1_pulse", start, 0);
    check("t1_x_zero", spawnX, 0);
    check("t1_y_zero", spawnY, 0);
    tick();
    check("t1_done", done, 1);
    check("t1_idle", busy, 0);

    // Scroll threshold: col 21 becomes due on the 9th shift.
    run = 1'b0;
    write_entry(4'd0, 8'd21, 10'd300);
    restart_pulse("t2");
    run = 1'b1;
    any = '0;
    for (int i = 0; i < 8; i++) begin
      Shift = 1'b1; tick(); Shift = 1'b0;
      any |= start;
      tick();
      any |= start;
    end
    check("t2_no_early", any, 0);
    check("t2_idle", busy, 0);
    exp_q.push_back('{4'b0001, 10'd500, 10'd300});
    Shift = 1'b1; tick(); Shift = 1'b0;
    wait_start("t2", 4, c);
    tick();
    check("t2_pulse", start, 0);

    // All slots busy: wait in SEEK, then take slot 2 when it frees.
    run = 1'b0;
    write_entry(4'd0, 8'd3, 10'd200);
    restart_pulse("t3");
    goomba_alive = 4'hF;
    run = 1'b1;
    any = '0;
    repeat (5) begin tick(); any |= start; end
    check("t3_no_start", any, 0);
    check("t3_busy", busy, 1);
    check("t3_count4", active_count, 4);
    goomba_alive = 4'b1011;
    #1;
    check("t3_count3", active_count, 3);
    exp_q.push_back('{4'b0100, 10'd500, 10'd200});
    wait_start("t3", 4, c);
    check("t3_latency", c <= 2, 1);
    goomba_alive = 4'hF;
    tick();

    // Two due entries, alive echoed one cycle after each start.
    run = 1'b0;
    write_entry(4'd0, 8'd2, 10'd100);
    write_entry(4'd1, 8'd4, 10'd120);
    restart_pulse("t4");
    goomba_alive = '0;
    exp_q.push_back('{4'b0001, 10'd500, 10'd100});
    exp_q.push_back('{4'b0010, 10'd500, 10'd120});
    run = 1'b1;
    wait_start("t4a", 4, c);
    tick();
    goomba_alive = 4'b0001;
    wait_start("t4b", 8, c2);
    check("t4_gap", (1 + c2) >= 3, 1);
    tick();
    goomba_alive = 4'b0011;
    tick();
    check("t4_done", done, 1);

    // Restart during SEEK: kill, rewind, entry 0 respawns.
    run = 1'b0;
    write_entry(4'd0, 8'd1, 10'd50);
    write_entry(4'd1, 8'd2, 10'd60);
    restart_pulse("t5a");
    goomba_alive = '0;
    exp_q.push_back('{4'b0001, 10'd500, 10'd50});
    run = 1'b1;
    wait_start("t5a", 4, c);
    tick();
    goomba_alive = 4'hF;
    tick(); tick(); tick();
    check("t5_seek", busy, 1);
    restart_pulse("t5b");
    goomba_alive = '0;
    exp_q.push_back('{4'b0001, 10'd500, 10'd50});
    wait_start("t5b", 4, c);

    // Reset in the middle of ISSUE.
    Reset_n = 1'b0;
    #1;
    check("t6_start", start, 0);
    check("t6_x", spawnX, 0);
    check("t6_y", spawnY, 0);
    check("t6_kill", kill, 0);
    check("t6_busy", busy, 0);
    #3;
    Reset_n = 1'b1;
    tick(); tick();
    check("t6_done", done, 1);
    any = '0;
    repeat (6) begin tick(); any |= start; end
    check("t6_no_start", any, 0);
    check("t6_sb_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
